ixu_regfile: RTL

Multi-ported integer register file shared by the VLIW integer issue lanes. It answers each IXU's ID/EX read requests (rs1/rs2 address in, data out) and commits each IXU's writeback (rd, data, write enable). It provides same-cycle write-to-read bypass and hardwires x0 to zero. It resolves simultaneous writes to one register deterministically and counts them.

---
 rtl/ixu_regfile.sv | 96 +++++++++
 1 files changed

// File: rtl/ixu_regfile.sv
// Multi-ported integer register file for the VLIW IXU lanes: 2 reads + 1 write per lane,
// x0 hardwired to zero, same-cycle write-to-read bypass, and a saturating write-conflict counter.
module ixu_regfile #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*LANES-1:0]    rs1_addr,
    input  logic [5*LANES-1:0]    rs2_addr,
    output logic [XLEN*LANES-1:0] rs1_data,
    output logic [XLEN*LANES-1:0] rs2_data,
    input  logic [5*LANES-1:0]    wr_addr,
    input  logic [XLEN*LANES-1:0] wr_data,
    input  logic [LANES-1:0]      wr_en,
    output logic [CNT_W-1:0]      conflict_cnt,
    output logic                  conflict_flag
);

    logic [XLEN-1:0]           regs [1:31];
    logic [LANES-1:0]          wr_valid;
    logic                      collide;
    logic [10*LANES-1:0]       rd_addr;
    logic [2*XLEN*LANES-1:0]   rd_data;
    logic [4:0]                rd_a;
    logic [XLEN-1:0]           rd_v;

    always_comb begin
        wr_valid = '0;
        collide  = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_valid[k] = wr_en[k] && (wr_addr[5*k +: 5] != 5'd0);
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (wr_valid[i] && wr_valid[j] && (wr_addr[5*i +: 5] == wr_addr[5*j +: 5])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // All 2*LANES read ports share one mux loop; ascending lane scan lets the highest lane win.
    assign rd_addr = {rs2_addr, rs1_addr};

    always_comb begin
        rd_data = '0;
        rd_a    = '0;
        rd_v    = '0;
        for (int unsigned p = 0; p < 2*LANES; p++) begin
            rd_a = rd_addr[5*p +: 5];
            rd_v = '0;
            if (rd_a != 5'd0) begin
                rd_v = regs[rd_a];
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (wr_valid[k] && (wr_addr[5*k +: 5] == rd_a)) begin
                        rd_v = wr_data[XLEN*k +: XLEN];
                    end
                end
            end
            rd_data[XLEN*p +: XLEN] = rd_v;
        end
    end

    assign rs1_data = rd_data[XLEN*LANES-1:0];
    assign rs2_data = rd_data[2*XLEN*LANES-1:XLEN*LANES];

    // Later non-blocking assignments override earlier ones, so the highest lane's data commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < 32; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (wr_valid[k]) begin
                    regs[wr_addr[5*k +: 5]] <= wr_data[XLEN*k +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt  <= '0;
            conflict_flag <= 1'b0;
        end else if (collide) begin
            conflict_flag <= 1'b1;
            if (conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
